// File: rtl/core_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// core_pkg: shared constants for the RV32I core front end.
// Rev 1.0
// ----------------------------------------------------------------------------
package core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned IMEM_AW   = 10;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_reg: program counter with redirect/stall priority and misalign flag.
// Rev 1.0
// ----------------------------------------------------------------------------
module pc_reg
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_f_i,
  input  logic            pc_src_e_i,
  input  logic [XLEN-1:0] pc_target_e_i,
  output logic [XLEN-1:0] pc_f_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_next;
  logic            misalign;
  logic            misalign_next;

  // Redirect outranks stall so a simultaneous request resolves deterministically.
  always_comb begin
    pc_next       = pc_f + XLEN'(4);
    misalign_next = 1'b0;
    if (pc_src_e_i) begin
      pc_next       = {pc_target_e_i[XLEN-1:2], 2'b00};
      misalign_next = |pc_target_e_i[1:0];
    end else if (stall_f_i) begin
      pc_next = pc_f;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_f     <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      pc_f     <= pc_next;
      misalign <= misalign_next;
    end
  end

  assign pc_f_o     = pc_f;
  assign misalign_o = misalign;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_stage: IF stage plus IF/ID register of the five-stage RV32I core.
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_stage
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = core_pkg::XLEN,
  parameter int unsigned     IMEM_AW  = core_pkg::IMEM_AW,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(core_pkg::RESET_PC)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_f_i,
  input  logic               stall_d_i,
  input  logic               flush_d_i,
  input  logic               pc_src_e_i,
  input  logic [XLEN-1:0]    pc_target_e_i,
  output logic               imem_en_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_rdata_i,
  output logic [XLEN-1:0]    pc_f_o,
  output logic [31:0]        instr_d_o,
  output logic [XLEN-1:0]    pc_d_o,
  output logic [XLEN-1:0]    pc_plus4_d_o,
  output logic               valid_d_o,
  output logic [4:0]         rs1_d_o,
  output logic [4:0]         rs2_d_o,
  output logic               misalign_o
);

  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_plus4_f;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_d;
  logic            valid_d;
  logic [31:0]     instr_d;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_f_i     (stall_f_i),
    .pc_src_e_i    (pc_src_e_i),
    .pc_target_e_i (pc_target_e_i),
    .pc_f_o        (pc_f),
    .misalign_o    (misalign_o)
  );

  assign pc_plus4_f = pc_f + XLEN'(4);

  // A disabled BRAM keeps its output register, holding the stalled instruction.
  assign imem_en_o   = ~stall_d_i | flush_d_i | rst_i;
  assign imem_addr_o = pc_f[IMEM_AW+1:2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_d    <= 1'b0;
      pc_d       <= RESET_PC;
      pc_plus4_d <= RESET_PC + XLEN'(4);
    end else if (flush_d_i) begin
      valid_d    <= 1'b0;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
    end else if (!stall_d_i) begin
      valid_d    <= 1'b1;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_plus4_f;
    end
  end

  assign instr_d = valid_d ? imem_rdata_i : NOP_INSTR;

  assign pc_f_o       = pc_f;
  assign instr_d_o    = instr_d;
  assign pc_d_o       = pc_d;
  assign pc_plus4_d_o = pc_plus4_d;
  assign valid_d_o    = valid_d;
  assign rs1_d_o      = instr_d[19:15];
  assign rs2_d_o      = instr_d[24:20];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;

  logic        imem_en;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, misalign;
  logic [4:0]  rs1_d, rs2_d;

  logic        w_imem_en;
  logic [9:0]  w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic [31:0] w_pc_f, w_instr_d, w_pc_d, w_pc_plus4_d;
  logic        w_valid_d, w_misalign;
  logic [4:0]  w_rs1_d, w_rs2_d;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [31:0] pc_d;
    logic [31:0] instr;
    logic [31:0] pc_f;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .IMEM_AW(10), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .stall_f_i(stall_f), .stall_d_i(stall_d),
    .flush_d_i(flush_d), .pc_src_e_i(pc_src_e), .pc_target_e_i(pc_target_e),
    .imem_en_o(imem_en), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .pc_f_o(pc_f), .instr_d_o(instr_d), .pc_d_o(pc_d), .pc_plus4_d_o(pc_plus4_d),
    .valid_d_o(valid_d), .rs1_d_o(rs1_d), .rs2_d_o(rs2_d), .misalign_o(misalign)
  );

  // Second instance exercises BRAM-address wrap from a high reset PC.
  fetch_stage #(.XLEN(32), .IMEM_AW(10), .RESET_PC(32'h0000_0FFC)) dut_w (
    .clk_i(clk), .rst_i(rst), .stall_f_i(1'b0), .stall_d_i(1'b0),
    .flush_d_i(1'b0), .pc_src_e_i(1'b0), .pc_target_e_i(32'h0),
    .imem_en_o(w_imem_en), .imem_addr_o(w_imem_addr), .imem_rdata_i(w_imem_rdata),
    .pc_f_o(w_pc_f), .instr_d_o(w_instr_d), .pc_d_o(w_pc_d), .pc_plus4_d_o(w_pc_plus4_d),
    .valid_d_o(w_valid_d), .rs1_d_o(w_rs1_d), .rs2_d_o(w_rs2_d), .misalign_o(w_misalign)
  );

  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= mem[imem_addr];
    if (w_imem_en) w_imem_rdata <= mem[w_imem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_pc_f", pc_f, 32'h0);
    chk("rst_valid", {31'b0, valid_d}, 32'h0);
    chk("rst_instr", instr_d, 32'h13);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_pc_plus4", pc_plus4_d, 32'h4);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_imem_en", {31'b0, imem_en}, 32'h1);
    chk("rst_imem_addr", {22'b0, imem_addr}, 32'h0);
  endtask

  // Push expectation, drive one cycle, then pop and compare after the edge.
  task automatic step(input logic sf, input logic sd, input logic fl, input logic src,
                      input logic [31:0] tgt, input logic ev, input logic [31:0] epc_d,
                      input logic [31:0] einstr, input logic [31:0] epc_f, input logic emis);
    exp_t e;
    exp_t got;
    logic [31:0] ei;
    e.valid = ev; e.pc_d = epc_d; e.instr = einstr; e.pc_f = epc_f; e.mis = emis;
    sb.push_back(e);
    checks++;
    assert (!(sd && !sf)) else begin
      errors++;
      $error("FAIL illegal_stall observed=%b%b expected=no stall_d without stall_f", sf, sd);
    end
    stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    ei  = got.instr;
    chk("valid_d", {31'b0, valid_d}, {31'b0, got.valid});
    chk("pc_d", pc_d, got.pc_d);
    chk("pc_plus4_d", pc_plus4_d, got.pc_d + 32'd4);
    chk("instr_d", instr_d, ei);
    chk("rs1_d", {27'b0, rs1_d}, {27'b0, ei[19:15]});
    chk("rs2_d", {27'b0, rs2_d}, {27'b0, ei[24:20]});
    chk("pc_f", pc_f, got.pc_f);
    chk("imem_addr", {22'b0, imem_addr}, {22'b0, got.pc_f[11:2]});
    chk("misalign", {31'b0, misalign}, {31'b0, got.mis});
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h100 + i;
    mem[1023] = 32'h01F2_8093;  // rs1=x5, rs2 field=31
    rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 1'b0; pc_target_e = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_state();
    chk("w_rst_pc_f", w_pc_f, 32'h0000_0FFC);
    chk("w_rst_imem_addr", {22'b0, w_imem_addr}, 32'h3FF);

    rst = 1'b0;
    chk("post_rst_valid", {31'b0, valid_d}, 32'h0);

    // Sequential fetch
    step(0, 0, 0, 0, 32'h0, 1, 32'h0, 32'h100, 32'h4, 0);
    chk("w_pc_f_wrap", w_pc_f, 32'h0000_1000);
    chk("w_imem_addr_wrap", {22'b0, w_imem_addr}, 32'h0);
    chk("w_instr_at_ffc", w_instr_d, 32'h01F2_8093);
    step(0, 0, 0, 0, 32'h0, 1, 32'h4, 32'h101, 32'h8, 0);
    step(0, 0, 0, 0, 32'h0, 1, 32'h8, 32'h102, 32'hC, 0);

    // Stall for three cycles
    step(1, 1, 0, 0, 32'h0, 1, 32'h8, 32'h102, 32'hC, 0);
    step(1, 1, 0, 0, 32'h0, 1, 32'h8, 32'h102, 32'hC, 0);
    step(1, 1, 0, 0, 32'h0, 1, 32'h8, 32'h102, 32'hC, 0);
    step(0, 0, 0, 0, 32'h0, 1, 32'hC, 32'h103, 32'h10, 0);

    // Redirect to 0x40
    step(0, 0, 1, 1, 32'h40, 0, 32'h10, 32'h13, 32'h40, 0);
    step(0, 0, 0, 0, 32'h0, 1, 32'h40, 32'h110, 32'h44, 0);

    // Stall and redirect together: redirect and flush win
    step(1, 1, 1, 1, 32'h20, 0, 32'h44, 32'h13, 32'h20, 0);
    step(0, 0, 0, 0, 32'h0, 1, 32'h20, 32'h108, 32'h24, 0);

    // Misaligned target
    step(0, 0, 1, 1, 32'h22, 0, 32'h24, 32'h13, 32'h20, 1);
    step(0, 0, 0, 0, 32'h0, 1, 32'h20, 32'h108, 32'h24, 0);

    // 32-bit PC wrap
    step(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h24, 32'h13, 32'hFFFF_FFFC, 0);
    step(0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h01F2_8093, 32'h0, 0);

    // Reset during stall
    step(1, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'h01F2_8093, 32'h0, 0);
    stall_f = 1'b1; stall_d = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0; stall_f = 1'b0; stall_d = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
